crc8_frame_checker: RTL and testbench

Receive-side counterpart to the team's pipelined CRC-8 generator. Accepts a codeword byte-serially over a valid/ready stream: N message bits followed by the k-bit CRC, MSB first. Recomputes the CRC-8 remainder across the whole codeword and reports pass/fail plus a length check on a held result handshake. Sits at the link receive boundary, downstream of the deserializer.

---
 rtl/crc8_pkg.sv | 19 +
 rtl/crc8_byte_step.sv | 25 ++
 rtl/crc8_frame_checker.sv | 176 +++++++++++++++++
 tb/tb_crc8_frame_checker.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions for the frame checker: CRC width, default polynomial,
// frame-length helper and FSM state encoding.
package crc8_pkg;

    localparam int unsigned CRC_K     = 8;
    localparam logic [7:0]  CRC8_POLY = 8'h07;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        REPORT = 2'd2
    } crc8_state_e;

    // Whole codeword length in bytes: message plus CRC byte.
    function automatic int unsigned frame_bytes(input int unsigned n);
        return (n + CRC_K) / 8;
    endfunction

endpackage

// File: rtl/crc8_byte_step.sv
// One byte of MSB-first CRC-8 long division: rem_out = step8(rem_in ^ byte_in).
module crc8_byte_step #(
    parameter logic [7:0] POLY = 8'h07
) (
    input  logic [7:0] rem_in,
    input  logic [7:0] byte_in,
    output logic [7:0] rem_out
);

    logic [7:0] crc_s;

    // Eight shift/conditional-XOR steps, earliest bit first.
    always_comb begin
        crc_s = rem_in ^ byte_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_s[7]) begin
                crc_s = {crc_s[6:0], 1'b0} ^ POLY;
            end else begin
                crc_s = {crc_s[6:0], 1'b0};
            end
        end
        rem_out = crc_s;
    end

endmodule

// File: rtl/crc8_frame_checker.sv
// Receive-side CRC-8 codeword checker with length check and held result handshake.
// Optional pass/fail statistics counters are enabled by defining CRC8_CHECK_STATS_EN.
module crc8_frame_checker
    import crc8_pkg::*;
#(
    parameter int unsigned N        = 64,
    parameter logic [7:0]  CRC_POLY = CRC8_POLY,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_crc_ok,
    output logic             out_len_err,
    output logic [7:0]       out_remainder,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam logic [7:0] FRAME_BYTES_C = 8'(frame_bytes(N));

    crc8_state_e state_r, state_next_s;
    logic        in_ready_r, in_ready_next_s;
    logic        out_valid_r, out_valid_next_s;
    logic [7:0]  rem_r, count_r, count_next_s;
    logic [7:0]  base_s, step_s;
    logic        out_crc_ok_r, out_len_err_r;
    logic [7:0]  out_remainder_r;
    logic        xfer_s, handshake_s, len_err_s, crc_ok_s;

    assign xfer_s      = in_valid && in_ready_r;
    assign handshake_s = out_valid_r && out_ready;

    // A new frame always divides from a zero base, whatever the last frame left.
    assign base_s = (state_r == IDLE) ? 8'h00 : rem_r;

    crc8_byte_step #(
        .POLY(CRC_POLY)
    ) u_step (
        .rem_in (base_s),
        .byte_in(in_data),
        .rem_out(step_s)
    );

    // Saturating byte count including the byte being accepted now.
    always_comb begin
        if (state_r == IDLE) begin
            count_next_s = 8'd1;
        end else if (count_r == 8'hFF) begin
            count_next_s = count_r;
        end else begin
            count_next_s = count_r + 8'd1;
        end
    end

    assign len_err_s = (count_next_s != FRAME_BYTES_C);
    assign crc_ok_s  = (step_s == 8'h00) && !len_err_s;

    // State and handshake-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= in_ready_next_s;
            out_valid_r <= out_valid_next_s;
        end
    end

    // Next-state logic; ready/valid are precomputed so they leave as flop outputs.
    always_comb begin
        state_next_s     = state_r;
        in_ready_next_s  = in_ready_r;
        out_valid_next_s = out_valid_r;
        case (state_r)
            IDLE, RECV: begin
                if (xfer_s && in_last) begin
                    state_next_s     = REPORT;
                    in_ready_next_s  = 1'b0;
                    out_valid_next_s = 1'b1;
                end else if (xfer_s) begin
                    state_next_s = RECV;
                end else begin
                    state_next_s = state_r;
                end
            end
            REPORT: begin
                if (handshake_s) begin
                    state_next_s     = IDLE;
                    in_ready_next_s  = 1'b1;
                    out_valid_next_s = 1'b0;
                end else begin
                    state_next_s = REPORT;
                end
            end
            default: begin
                state_next_s     = IDLE;
                in_ready_next_s  = 1'b1;
                out_valid_next_s = 1'b0;
            end
        endcase
    end

    // Running remainder, byte count and held result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r           <= 8'h00;
            count_r         <= 8'd0;
            out_crc_ok_r    <= 1'b0;
            out_len_err_r   <= 1'b0;
            out_remainder_r <= 8'h00;
        end else if (xfer_s) begin
            rem_r   <= step_s;
            count_r <= count_next_s;
            if (in_last) begin
                out_crc_ok_r    <= crc_ok_s;
                out_len_err_r   <= len_err_s;
                out_remainder_r <= step_s;
            end else begin
                out_crc_ok_r    <= out_crc_ok_r;
                out_len_err_r   <= out_len_err_r;
                out_remainder_r <= out_remainder_r;
            end
        end else begin
            rem_r   <= rem_r;
            count_r <= count_r;
        end
    end

    assign in_ready      = in_ready_r;
    assign out_valid     = out_valid_r;
    assign out_crc_ok    = out_crc_ok_r;
    assign out_len_err   = out_len_err_r;
    assign out_remainder = out_remainder_r;

`ifdef CRC8_CHECK_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

    logic [CNT_W-1:0] good_cnt_r, bad_cnt_r;

    // Saturating per-result statistics, counted at the result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt_r <= {CNT_W{1'b0}};
            bad_cnt_r  <= {CNT_W{1'b0}};
        end else if (handshake_s) begin
            if (out_crc_ok_r && (good_cnt_r != CNT_MAX_C)) begin
                good_cnt_r <= good_cnt_r + CNT_ONE_C;
            end else if (!out_crc_ok_r && (bad_cnt_r != CNT_MAX_C)) begin
                bad_cnt_r <= bad_cnt_r + CNT_ONE_C;
            end else begin
                good_cnt_r <= good_cnt_r;
                bad_cnt_r  <= bad_cnt_r;
            end
        end else begin
            good_cnt_r <= good_cnt_r;
            bad_cnt_r  <= bad_cnt_r;
        end
    end

    assign good_cnt = good_cnt_r;
    assign bad_cnt  = bad_cnt_r;
`else
    assign good_cnt = {CNT_W{1'b0}};
    assign bad_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Directed self-checking bench for crc8_frame_checker; counter expectations
// follow whether CRC8_CHECK_STATS_EN is defined.
module tb_crc8_frame_checker;

    localparam int unsigned TB_CNT_W = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [7:0]          in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic                out_crc_ok;
    logic                out_len_err;
    logic [7:0]          out_remainder;
    logic [TB_CNT_W-1:0] good_cnt;
    logic [TB_CNT_W-1:0] bad_cnt;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] frm [16];

    always #5 clk = ~clk;

    crc8_frame_checker #(
        .N       (64),
        .CRC_POLY(8'h07),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_crc_ok   (out_crc_ok),
        .out_len_err  (out_len_err),
        .out_remainder(out_remainder),
        .good_cnt     (good_cnt),
        .bad_cnt      (bad_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a negedge; holds the byte until the DUT accepts it.
    task automatic send_byte(input logic [7:0] d, input logic last);
        logic rdy;
        int   guard;
        rdy      = 1'b0;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!rdy && guard < 50) begin
            rdy = in_ready;
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        if (!rdy) check_eq("byte_accept_timeout", {31'd0, rdy}, 32'd1);
    endtask

    task automatic send_frame(input int len, input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(frm[i], (i == len - 1));
        end
        check_eq("latency_out_valid", {31'd0, out_valid}, 32'd1);
        check_eq("report_in_ready", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic get_result(input string tag, input logic ok, input logic len_err, input logic [7:0] rem);
        int guard;
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check_eq({tag, "_crc_ok"}, {31'd0, out_crc_ok}, {31'd0, ok});
        check_eq({tag, "_len_err"}, {31'd0, out_len_err}, {31'd0, len_err});
        check_eq({tag, "_remainder"}, {24'd0, out_remainder}, {24'd0, rem});
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic load_zero();
        for (int i = 0; i < 16; i++) frm[i] = 8'h00;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("reset_crc_ok", {31'd0, out_crc_ok}, 32'd0);
        check_eq("reset_len_err", {31'd0, out_len_err}, 32'd0);
        check_eq("reset_remainder", {24'd0, out_remainder}, 32'd0);
        check_eq("reset_good_cnt", {30'd0, good_cnt}, 32'd0);
        check_eq("reset_bad_cnt", {30'd0, bad_cnt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // All-zero codeword.
        load_zero();
        send_frame(9, 1'b0);
        get_result("zero9", 1'b1, 1'b0, 8'h00);

        // Message ...01 has CRC 07; corrupting CRC to 06 leaves remainder 07.
        frm[7] = 8'h01;
        frm[8] = 8'h07;
        send_frame(9, 1'b0);
        get_result("msg01_good", 1'b1, 1'b0, 8'h00);
        frm[8] = 8'h06;
        send_frame(9, 1'b0);
        get_result("msg01_bad", 1'b0, 1'b0, 8'h07);

        // Message ...FF has CRC F3; gaps upstream, consumer stalls five cycles.
        frm[7] = 8'hFF;
        frm[8] = 8'hF3;
        send_frame(9, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
            check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check_eq("stall_remainder", {24'd0, out_remainder}, 32'h0);
            check_eq("stall_crc_ok", {31'd0, out_crc_ok}, 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        get_result("msgff_stall", 1'b1, 1'b0, 8'h00);

        // Short and long frames.
        load_zero();
        send_frame(8, 1'b0);
        get_result("short8", 1'b0, 1'b1, 8'h00);
        send_frame(10, 1'b0);
        get_result("long10", 1'b0, 1'b1, 8'h00);

        // Abort mid-frame, then a clean frame must count from scratch.
        for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b0);
        pulse_reset();
        send_frame(9, 1'b0);
        get_result("post_abort", 1'b1, 1'b0, 8'h00);
        repeat (5) @(negedge clk);
        check_eq("no_extra_result", {31'd0, out_valid}, 32'd0);

        // Statistics: five good frames then one bad.
        pulse_reset();
        for (int f = 0; f < 5; f++) begin
            send_frame(9, 1'b0);
            get_result("stats_good", 1'b1, 1'b0, 8'h00);
            if (f == 1) begin
`ifdef CRC8_CHECK_STATS_EN
                check_eq("good_cnt_mid", {30'd0, good_cnt}, 32'd2);
`else
                check_eq("good_cnt_mid", {30'd0, good_cnt}, 32'd0);
`endif
            end
        end
        frm[7] = 8'h01;
        frm[8] = 8'h06;
        send_frame(9, 1'b0);
        get_result("stats_bad", 1'b0, 1'b0, 8'h07);
`ifdef CRC8_CHECK_STATS_EN
        check_eq("good_cnt_sat", {30'd0, good_cnt}, 32'd3);
        check_eq("bad_cnt", {30'd0, bad_cnt}, 32'd1);
`else
        check_eq("good_cnt_tied", {30'd0, good_cnt}, 32'd0);
        check_eq("bad_cnt_tied", {30'd0, bad_cnt}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
